reg_file_sb: RTL

- Parametrised successor to the integer register file: N read ports, two write ports, same-cycle write-to-read bypass and a per-register pending-write scoreboard.
- Sits between decode/issue and the write-back stage.
- Supplies operands plus busy flags so issue logic can stall on RAW hazards without a separate scoreboard block.

---
 rtl/reg_file_sb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//   Integer register file with NRD combinational read ports, two write ports,
//   same-cycle write-to-read bypass and a per-register pending-write
//   scoreboard. It sits between decode/issue and write-back. It returns
//   operands together with busy flags, so issue logic can stall on RAW
//   hazards without a separate scoreboard block.
//
// Ports
//   clk       in   1          rising-edge clock
//   rst_n     in   1          asynchronous active-low reset
//   rs_addr   in   NRD*AW     read addresses, port k at [k*AW +: AW]
//   rs_data   out  NRD*XLEN   read data, port k at [k*XLEN +: XLEN]
//   rs_busy   out  NRD        port k's register awaits a non-bypassable write
//   wr0_*     in              primary write-back (ALU), highest priority
//   wr1_*     in              secondary write-back (load/mul)
//   iss_en    in   1          instruction with a destination issues now
//   iss_rd    in   AW         destination of the issuing instruction
//   pend_cnt  out  AW+1       number of registers currently marked busy
// ---------------------------------------------------------------------------
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic [AW:0]         pend_cnt
);

  localparam bit LP_ZERO = (ZERO_REG != 0);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_pend_cnt;

  logic [NREG-1:0] w_wr0_dec;
  logic [NREG-1:0] w_wr1_dec;
  logic [NREG-1:0] w_iss_dec;
  logic [NREG-1:0] w_busy_nxt;
  logic [AW:0]     w_pop;

  // One-hot decode of each write/issue target. A hardwired-zero register 0
  // never decodes, so it cannot be written and cannot become busy.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
    localparam bit LP_WRITABLE = !(LP_ZERO && (gi == 0));
    assign w_wr0_dec[gi] = LP_WRITABLE && wr0_en && (wr0_addr == AW'(gi));
    assign w_wr1_dec[gi] = LP_WRITABLE && wr1_en && (wr1_addr == AW'(gi));
    assign w_iss_dec[gi] = LP_WRITABLE && iss_en && (iss_rd   == AW'(gi));
  end

  // Storage. Port 0 wins a same-address collision, matching the bypass order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_wr0_dec[i]) begin
          r_regs[i] <= wr0_data;
        end else if (w_wr1_dec[i]) begin
          r_regs[i] <= wr1_data;
        end
      end
    end
  end

  // The set is applied after the clear, so a retiring producer and a new
  // issue to the same register in one cycle leave the register busy.
  always_comb begin
    w_busy_nxt = (r_busy & ~(w_wr0_dec | w_wr1_dec)) | w_iss_dec;
  end

  // pend_cnt is registered from the next-state vector, so after each edge
  // it equals the popcount of the busy bits that were just stored.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NREG; i++) begin
      w_pop = w_pop + (AW + 1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= w_pop;
    end
  end

  assign pend_cnt = r_pend_cnt;

  // Read ports: zero register, then wr0 bypass, then wr1 bypass, then storage.
  for (genvar gk = 0; gk < NRD; gk++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic            w_zero;
    logic            w_hit0;
    logic            w_hit1;
    logic [XLEN-1:0] w_data;

    assign w_addr = rs_addr[gk*AW +: AW];
    assign w_zero = LP_ZERO && (w_addr == '0);
    assign w_hit0 = wr0_en && (wr0_addr == w_addr);
    assign w_hit1 = wr1_en && (wr1_addr == w_addr);

    always_comb begin
      w_data = r_regs[w_addr];
      if (w_zero) begin
        w_data = '0;
      end else if (w_hit0) begin
        w_data = wr0_data;
      end else if (w_hit1) begin
        w_data = wr1_data;
      end
    end

    assign rs_data[gk*XLEN +: XLEN] = w_data;
    // A write landing this cycle is bypassed, so the operand is usable now.
    // A same-cycle issue does not affect this until the following cycle.
    assign rs_busy[gk] = r_busy[w_addr] && !w_hit0 && !w_hit1 && !w_zero;
  end

endmodule
